// File: rtl/time_set_input.sv
// Push-button front end (synchronise, debounce, edge-detect) and the MM:SS edit FSM
// that lets the user pick a BCD digit, step it up/down, and commit it via a load strobe.
module time_set_input #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
  input  logic        clk_osc,
  input  logic        reset_n,
  input  logic [4:0]  push,
  input  logic [15:0] time_in,
  output logic [4:0]  press,
  output logic        edit_active,
  output logic [1:0]  digit_sel,
  output logic [15:0] time_out,
  output logic        time_load
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam int B_U = 0;
  localparam int B_D = 1;
  localparam int B_L = 2;
  localparam int B_R = 3;
  localparam int B_M = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  logic [4:0]         sync1_q, sync2_q;
  logic [4:0]         stable_q, stable_d, stable_dly_q;
  logic [4:0]         press_q;
  logic [4:0][DW-1:0] deb_cnt_q, deb_cnt_d;

  always_ff @(posedge clk_osc or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      deb_cnt_q    <= '0;
      press_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values,
      // which is what makes sync1 -> sync2 a real two-stage pipeline.
      sync1_q      <= push;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      deb_cnt_q    <= deb_cnt_d;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    stable_d  = stable_q;
    deb_cnt_d = '0;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) stable_d[i] = sync2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  // One action per cycle: m > u > d > l > r.
  logic any_press, act_m, act_u, act_d, act_l, act_r;

  always_comb begin
    any_press = |press_q;
    act_m     = press_q[B_M];
    act_u     = press_q[B_U] & ~press_q[B_M];
    act_d     = press_q[B_D] & ~|{press_q[B_M], press_q[B_U]};
    act_l     = press_q[B_L] & ~|{press_q[B_M], press_q[B_U], press_q[B_D]};
    act_r     = press_q[B_R] & ~|{press_q[B_M], press_q[B_U], press_q[B_D], press_q[B_L]};
  end

  state_e        state_q, state_d;
  logic [15:0]   time_out_q, time_out_d;
  logic [1:0]    digit_sel_q, digit_sel_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Tens-of-minutes and tens-of-seconds digits (odd positions) top out at 5.
  logic [3:0] digit_lsb, cur_digit, max_digit, inc_digit, dec_digit;

  always_comb begin
    digit_lsb = {digit_sel_q, 2'b00};
    cur_digit = time_out_q[digit_lsb +: 4];
    max_digit = digit_sel_q[0] ? 4'd5 : 4'd9;
    inc_digit = (cur_digit >= max_digit) ? 4'd0 : cur_digit + 4'd1;
    dec_digit = (cur_digit == 4'd0 || cur_digit > max_digit) ? max_digit
                                                              : cur_digit - 4'd1;
  end

  always_ff @(posedge clk_osc or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (act_m) state_d = EDIT;
      EDIT: begin
        if (act_m)                                   state_d = COMMIT;
        else if (!any_press && to_cnt_q == TO_LAST)  state_d = IDLE;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    time_out_d  = time_out_q;
    digit_sel_d = digit_sel_q;
    to_cnt_d    = to_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (act_m) begin
          time_out_d  = time_in;
          digit_sel_d = 2'd3;
          to_cnt_d    = '0;
        end
      end
      EDIT: begin
        if (any_press)              to_cnt_d = '0;
        else if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + TW'(1);

        if (act_u)      time_out_d[digit_lsb +: 4] = inc_digit;
        else if (act_d) time_out_d[digit_lsb +: 4] = dec_digit;
        else if (act_l) digit_sel_d = digit_sel_q + 2'd1;
        else if (act_r) digit_sel_d = digit_sel_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_osc or negedge reset_n) begin
    if (!reset_n) begin
      time_out_q  <= '0;
      digit_sel_q <= 2'd3;
      to_cnt_q    <= '0;
    end else begin
      time_out_q  <= time_out_d;
      digit_sel_q <= digit_sel_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_comb begin
    edit_active = (state_q == EDIT);
    time_load   = (state_q == COMMIT);
  end

  assign press     = press_q;
  assign digit_sel = digit_sel_q;
  assign time_out  = time_out_q;

endmodule

// File: tb/tb_time_set_input.sv
// Scoreboarded bench for time_set_input: a digit-level model queues expected press
// effects and committed values; independent monitors compare when the DUT reports them.
module tb_time_set_input;

  localparam int DEB = 4;
  localparam int TO  = 64;

  logic        clk_osc = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  push    = '0;
  logic [15:0] time_in = '0;
  logic [4:0]  press;
  logic        edit_active;
  logic [1:0]  digit_sel;
  logic [15:0] time_out;
  logic        time_load;

  time_set_input #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_osc     (clk_osc),
    .reset_n     (reset_n),
    .push        (push),
    .time_in     (time_in),
    .press       (press),
    .edit_active (edit_active),
    .digit_sel   (digit_sel),
    .time_out    (time_out),
    .time_load   (time_load)
  );

  always #5 clk_osc = ~clk_osc;

  int cyc = 0;
  always @(posedge clk_osc) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  mask;
    logic        edit;
    logic [1:0]  sel;
    logic [15:0] tout;
  } exp_t;

  exp_t        exp_press_q[$];
  logic [15:0] exp_load_q[$];

  // Reference model: four digits, a cursor and an editing flag.
  bit         m_edit = 1'b0;
  int         m_sel  = 3;
  logic [3:0] md[4]  = '{4'd0, 4'd0, 4'd0, 4'd0};

  function automatic int digit_max(input int pos);
    return (pos % 2 == 1) ? 5 : 9;
  endfunction

  function automatic logic [15:0] model_value();
    return {md[3], md[2], md[1], md[0]};
  endfunction

  task automatic model_reset();
    m_edit = 1'b0;
    m_sel  = 3;
    for (int k = 0; k < 4; k++) md[k] = 4'd0;
  endtask

  task automatic model_apply(input logic [4:0] mask);
    exp_t e;
    int   v, mx;
    v  = int'(md[m_sel]);
    mx = digit_max(m_sel);
    if (!m_edit) begin
      if (mask[4]) begin
        m_edit = 1'b1;
        m_sel  = 3;
        for (int k = 0; k < 4; k++) md[k] = time_in[4*k +: 4];
      end
    end else if (mask[4]) begin
      exp_load_q.push_back(model_value());
      m_edit = 1'b0;
    end else if (mask[0]) begin
      md[m_sel] = (v + 1 > mx) ? 4'd0 : 4'(v + 1);
    end else if (mask[1]) begin
      md[m_sel] = (v == 0 || v > mx) ? 4'(mx) : 4'(v - 1);
    end else if (mask[2]) begin
      m_sel = (m_sel + 1) % 4;
    end else if (mask[3]) begin
      m_sel = (m_sel + 3) % 4;
    end
    e.mask = mask;
    e.edit = m_edit;
    e.sel  = 2'(m_sel);
    e.tout = model_value();
    exp_press_q.push_back(e);
  endtask

  // Press monitor: each pulse must match the queued press, and the cycle after it
  // the edit state must match the model.
  int last_press_cyc = 0;
  int n_bit0_pulses  = 0;
  initial forever begin
    exp_t e;
    @(negedge clk_osc);
    if (press !== 5'b0) begin
      last_press_cyc = cyc;
      if (press[0]) n_bit0_pulses++;
      if (exp_press_q.size() == 0) begin
        check("unexpected_press", 32'(press), 32'd0);
      end else begin
        e = exp_press_q.pop_front();
        check("press_mask", 32'(press), 32'(e.mask));
        @(negedge clk_osc);
        check("press_width", 32'(press), 32'd0);
        check("edit_active", 32'(edit_active), 32'(e.edit));
        check("digit_sel", 32'(digit_sel), 32'(e.sel));
        check("time_out", 32'(time_out), 32'(e.tout));
      end
    end
  end

  // Load monitor: each strobe must carry the queued committed value and last one cycle.
  int n_loads = 0;
  initial forever begin
    logic [15:0] v;
    @(negedge clk_osc);
    if (time_load === 1'b1) begin
      n_loads++;
      if (exp_load_q.size() == 0) begin
        check("unexpected_load", 32'(time_load), 32'd0);
      end else begin
        v = exp_load_q.pop_front();
        check("load_value", 32'(time_out), 32'(v));
      end
      @(negedge clk_osc);
      check("load_width", 32'(time_load), 32'd0);
      check("idle_after_load", 32'(edit_active), 32'd0);
    end
  end

  initial begin
    repeat (30000) @(posedge clk_osc);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1);
  end

  task automatic do_press(input logic [4:0] mask);
    model_apply(mask);
    @(negedge clk_osc);
    push = mask;
    repeat (10) @(negedge clk_osc);
    push = '0;
    repeat (10) @(negedge clk_osc);
  endtask

  // Waits for edit_active to drop; returns the cycle it was first seen low, or -1.
  task automatic wait_fall(output int fc);
    fc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_osc);
      if (!edit_active) begin
        fc = cyc;
        break;
      end
    end
    if (fc < 0) check("timeout_bound", 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] rand_time();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    int hold_cyc, pulses0, loads0, entry_cyc, fall_cyc;

    repeat (3) @(negedge clk_osc);
    check("rst_press", 32'(press), 32'd0);
    check("rst_edit", 32'(edit_active), 32'd0);
    check("rst_sel", 32'(digit_sel), 32'd3);
    check("rst_time_out", 32'(time_out), 32'd0);
    check("rst_load", 32'(time_load), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_osc);

    // Bouncing input: no pulse while toggling, one pulse DEB+3 cycles after a clean hold.
    pulses0 = n_bit0_pulses;
    for (int i = 0; i < 20; i++) begin
      push[0] = ((i / 2) % 2 == 0);
      @(negedge clk_osc);
    end
    check("bounce_no_pulse", 32'(n_bit0_pulses - pulses0), 32'd0);
    model_apply(5'b00001);
    push     = 5'b00001;
    hold_cyc = cyc;
    repeat (12) @(negedge clk_osc);
    check("press_latency", 32'(last_press_cyc - hold_cyc), 32'(DEB + 3));
    push = '0;
    repeat (12) @(negedge clk_osc);
    check("bounce_one_pulse", 32'(n_bit0_pulses - pulses0), 32'd1);

    // Enter / edit / commit.
    time_in = 16'h2359;
    do_press(5'b10000);
    do_press(5'b00100);
    do_press(5'b00001);
    check("t2_value", 32'(time_out), 32'h2350);
    do_press(5'b10000);
    check("t2_idle", 32'(edit_active), 32'd0);

    // Digit wrap in both directions.
    time_in = 16'h5959;
    do_press(5'b10000);
    do_press(5'b00001);
    check("t3_m10_wrap", 32'(time_out), 32'h0959);
    do_press(5'b01000);
    do_press(5'b01000);
    do_press(5'b01000);
    check("t3_sel0", 32'(digit_sel), 32'd0);
    do_press(5'b00010);
    check("t3_dec", 32'(time_out), 32'h0958);
    do_press(5'b00001);
    do_press(5'b00001);
    check("t3_s1_wrap", 32'(time_out), 32'h0950);
    do_press(5'b10000);

    // Simultaneous presses follow priority.
    time_in = 16'h1234;
    do_press(5'b10000);
    do_press(5'b00011);
    check("t4_u_over_d", 32'(time_out), 32'h2234);
    do_press(5'b10001);
    check("t4_m_over_u", 32'(time_out), 32'h2234);
    check("t4_idle", 32'(edit_active), 32'd0);

    // Timeout with no presses, then a late press that restarts the count.
    loads0  = n_loads;
    time_in = 16'h0102;
    do_press(5'b10000);
    wait_fall(fall_cyc);
    check("t5_timeout_len", 32'(fall_cyc - last_press_cyc), 32'(TO + 1));
    m_edit = 1'b0;
    do_press(5'b10000);
    entry_cyc = last_press_cyc;
    repeat (40) @(negedge clk_osc);
    do_press(5'b00100);
    wait_fall(fall_cyc);
    check("t5_restart_len", 32'(fall_cyc - last_press_cyc), 32'(TO + 1));
    check("t5_restart_extends", 32'(fall_cyc - entry_cyc > TO + 1), 32'd1);
    m_edit = 1'b0;
    repeat (5) @(negedge clk_osc);
    check("t5_no_load", 32'(n_loads - loads0), 32'd0);

    // Reset in the middle of an edit.
    loads0  = n_loads;
    time_in = 16'h4321;
    do_press(5'b10000);
    do_press(5'b00100);
    @(negedge clk_osc);
    reset_n = 1'b0;
    #1;
    check("t6_press", 32'(press), 32'd0);
    check("t6_edit", 32'(edit_active), 32'd0);
    check("t6_sel", 32'(digit_sel), 32'd3);
    check("t6_time_out", 32'(time_out), 32'd0);
    check("t6_load", 32'(time_load), 32'd0);
    @(negedge clk_osc);
    reset_n = 1'b1;
    model_reset();
    do_press(5'b00001);
    check("t6_stay_idle", 32'(edit_active), 32'd0);
    check("t6_no_load", 32'(n_loads - loads0), 32'd0);
    do_press(5'b10000);
    check("t6_reenter", 32'(edit_active), 32'd1);
    do_press(5'b10000);

    // Randomised button traffic against the model.
    for (int n = 0; n < 60; n++) begin
      time_in = rand_time();
      do_press(5'($urandom_range(1, 31)));
    end
    if (m_edit) do_press(5'b10000);
    repeat (10) @(negedge clk_osc);
    check("press_queue_drained", 32'(exp_press_q.size()), 32'd0);
    check("load_queue_drained", 32'(exp_load_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
